// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU function codes, sequencer state type and supported-code check
package alu_pkg;

  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000001;
  localparam logic [5:0] FN_MUL = 6'b000010;
  localparam logic [5:0] FN_AND = 6'b000100;
  localparam logic [5:0] FN_OR  = 6'b000101;
  localparam logic [5:0] FN_XOR = 6'b000110;
  localparam logic [5:0] FN_SLL = 6'b001000;
  localparam logic [5:0] FN_SRL = 6'b001001;
  localparam logic [5:0] FN_SLT = 6'b001011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  function automatic logic is_supported_fn(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_MUL, FN_AND, FN_OR,
      FN_XOR, FN_SLL, FN_SRL, FN_SLT: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_rr_arb2.sv
// rtl/alu_share_rr_arb2.sv - two-input round-robin arbiter; ALU_SHARE_FIXED_PRIO_EN selects fixed priority to input 0
module alu_share_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = valid0 | valid1;

`ifdef ALU_SHARE_FIXED_PRIO_EN
  logic unused_fixed;
  assign unused_fixed = ^{clk, rst, advance};
  assign grant_id     = ~valid0;
`else
  // ptr names the requester that wins the next contested grant
  logic ptr;

  always_comb begin
    if (valid0 && valid1) grant_id = ptr;
    else                  grant_id = ~valid0;
  end

  always_ff @(posedge clk) begin
    if (rst)                               ptr <= 1'b0;
    else if (advance && valid0 && valid1)  ptr <= ~grant_id;
  end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one ALU between two requesters; ALU_SHARE_FIXED_PRIO_EN selects fixed priority
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [5:0]  req0_alufn,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [5:0]  req1_alufn,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_result,
  output logic        resp0_zero,
  output logic        resp0_overflow,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_result,
  output logic        resp1_zero,
  output logic        resp1_overflow,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fn,
  input  logic [31:0] alu_otp,
  input  logic        alu_zero,
  input  logic        alu_overflow
);

  localparam logic [3:0] MUL_DWELL = 4'(MUL_LAT - 1);

  state_t      state, state_nxt;
  logic        owner;
  logic [3:0]  cnt;
  logic        grant_valid, grant_id;
  logic        accept, exec_done, consume;
  logic [5:0]  acc_fn;
  logic [31:0] res_q;
  logic        zero_q, ovf_q;

  alu_share_rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .advance     (accept),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign accept     = (state == ST_IDLE) && grant_valid;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign acc_fn     = grant_id ? req1_alufn : req0_alufn;
  assign exec_done  = (state == ST_EXEC) && (cnt == 4'd0);
  assign consume    = (state == ST_RESP) && (owner ? resp1_ready : resp0_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_EXEC;
      ST_EXEC: if (exec_done) state_nxt = ST_RESP;
      ST_RESP: if (consume)   state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Operand registers double as the ALU drive, so they hold outside EXEC for free
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a  <= 32'd0;
      alu_b  <= 32'd0;
      alu_fn <= 6'd0;
      owner  <= 1'b0;
      cnt    <= 4'd0;
      res_q  <= 32'd0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        alu_a  <= grant_id ? req1_a : req0_a;
        alu_b  <= grant_id ? req1_b : req0_b;
        alu_fn <= acc_fn;
        owner  <= grant_id;
        cnt    <= (acc_fn == FN_MUL) ? MUL_DWELL : 4'd0;
      end else if ((state == ST_EXEC) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (exec_done) begin
        if (is_supported_fn(alu_fn)) begin
          res_q  <= alu_otp;
          zero_q <= alu_zero;
          ovf_q  <= alu_overflow;
        end else begin
          res_q  <= 32'd0;
          zero_q <= 1'b1;
          ovf_q  <= 1'b0;
        end
      end
    end
  end

  assign resp0_valid    = (state == ST_RESP) && !owner;
  assign resp1_valid    = (state == ST_RESP) && owner;
  assign resp0_result   = res_q;
  assign resp0_zero     = zero_q;
  assign resp0_overflow = ovf_q;
  assign resp1_result   = res_q;
  assign resp1_zero     = zero_q;
  assign resp1_overflow = ovf_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - self-checking bench for alu_share_ctrl with a transaction-level reference model
module tb_alu_share_ctrl;

  localparam int MUL_LAT = 3;
`ifdef ALU_SHARE_FIXED_PRIO_EN
  localparam int EXP_B2 = 0;
`else
  localparam int EXP_B2 = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [5:0]  req0_alufn = '0, req1_alufn = '0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [31:0] resp0_result, resp1_result;
  logic        resp0_zero, resp1_zero, resp0_overflow, resp1_overflow;
  logic [31:0] alu_a, alu_b, alu_otp;
  logic [5:0]  alu_fn;
  logic        alu_zero, alu_overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_alufn(req0_alufn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_alufn(req1_alufn),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
    .resp0_zero(resp0_zero), .resp0_overflow(resp0_overflow),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
    .resp1_zero(resp1_zero), .resp1_overflow(resp1_overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
    .alu_otp(alu_otp), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  // Environment ALU; unsupported codes produce junk that the controller must ignore
  function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn);
    logic [31:0] r;
    logic        ov;
    ov = 1'b0;
    case (fn)
      6'b000000: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      6'b000001: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      6'b000010: r = a * b;
      6'b000100: r = a & b;
      6'b000101: r = a | b;
      6'b000110: r = a ^ b;
      6'b001000: r = a << b[4:0];
      6'b001001: r = a >> b[4:0];
      6'b001011: r = {31'd0, ($signed(a) < $signed(b))};
      default:   return {1'b1, 1'b0, 32'hDEADBEEF};
    endcase
    return {ov, (r == 32'd0), r};
  endfunction

  function automatic logic supported(input logic [5:0] fn);
    return fn inside {6'b000000, 6'b000001, 6'b000010, 6'b000100, 6'b000101,
                      6'b000110, 6'b001000, 6'b001001, 6'b001011};
  endfunction

  assign {alu_overflow, alu_zero, alu_otp} = alu_ref(alu_a, alu_b, alu_fn);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding operation, response due a fixed dwell after acceptance
  logic        m_busy = 1'b0, m_owner = 1'b0, m_ptr = 1'b0;
  int          m_due = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [5:0]  m_fn = '0;
  logic [33:0] m_exp = '0;

  always @(negedge clk) begin
    logic g, any, both, e_v0, e_v1;
    any  = req0_valid | req1_valid;
    both = req0_valid & req1_valid;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    g = both ? 1'b0 : req1_valid;
`else
    g = both ? m_ptr : req1_valid;
`endif
    chk("mon_req0_ready", req0_ready, !m_busy && any && !g);
    chk("mon_req1_ready", req1_ready, !m_busy && any && g);
    e_v0 = m_busy && (cyc >= m_due) && !m_owner;
    e_v1 = m_busy && (cyc >= m_due) && m_owner;
    chk("mon_resp0_valid", resp0_valid, e_v0);
    chk("mon_resp1_valid", resp1_valid, e_v1);
    if (m_busy && cyc < m_due) begin
      chk("mon_alu_a", alu_a, m_a);
      chk("mon_alu_b", alu_b, m_b);
      chk("mon_alu_fn", alu_fn, m_fn);
    end
    if (e_v0) begin
      chk("mon_resp0_result", resp0_result, m_exp[31:0]);
      chk("mon_resp0_zero", resp0_zero, m_exp[32]);
      chk("mon_resp0_ovf", resp0_overflow, m_exp[33]);
    end
    if (e_v1) begin
      chk("mon_resp1_result", resp1_result, m_exp[31:0]);
      chk("mon_resp1_zero", resp1_zero, m_exp[32]);
      chk("mon_resp1_ovf", resp1_overflow, m_exp[33]);
    end
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 1'b0;
    end else if (!m_busy) begin
      if (any) begin
        m_busy  = 1'b1;
        m_owner = g;
        m_a     = g ? req1_a : req0_a;
        m_b     = g ? req1_b : req0_b;
        m_fn    = g ? req1_alufn : req0_alufn;
        m_due   = cyc + 1 + ((m_fn == 6'b000010) ? MUL_LAT : 1);
        m_exp   = supported(m_fn) ? alu_ref(m_a, m_b, m_fn) : {1'b0, 1'b1, 32'd0};
        if (both) m_ptr = !g;
      end
    end else if (cyc >= m_due && (m_owner ? resp1_ready : resp0_ready)) begin
      m_busy = 1'b0;
    end
  end

  task automatic wait_accept(output int who, output int t);
    who = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin who = 0; break; end
      if (req1_valid && req1_ready) begin who = 1; break; end
    end
    @(posedge clk);
    #1;
    t = cyc;
    if (who < 0) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_valid(input int n, input int t, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((n == 0) ? resp0_valid : resp1_valid) begin lat = cyc - t; break; end
    end
    if (lat < 0) chk("resp_timeout", 32'd1, 32'd0);
  endtask

  task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn);
    req0_a = a; req0_b = b; req0_alufn = fn; req0_valid = 1'b1;
  endtask

  task automatic set1(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn);
    req1_a = a; req1_b = b; req1_alufn = fn; req1_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int who, t, lat, w1, w2;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_resp0_valid", resp0_valid, 1'b0);
    chk("rst_resp1_valid", resp1_valid, 1'b0);
    chk("rst_result", resp0_result, 32'd0);
    chk("rst_zero", resp0_zero, 1'b0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_fn", alu_fn, 6'd0);

    // ADD 5+7 from requester 0
    @(posedge clk); #1;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    set0(32'd5, 32'd7, 6'b000000);
    wait_accept(who, t);
    req0_valid = 1'b0;
    chk("add_grant", who, 0);
    wait_valid(0, t, lat);
    chk("add_latency", lat, 1);
    chk("add_result", resp0_result, 32'd12);
    chk("add_zero", resp0_zero, 1'b0);
    chk("add_ovf", resp0_overflow, 1'b0);

    // Two contested rounds
    @(posedge clk); #1;
    set0(32'd1, 32'd2, 6'b000000);
    set1(32'd3, 32'd4, 6'b000000);
    wait_accept(w1, t);
    chk("arb_first", w1, 0);
    wait_valid(w1, t, lat);
    wait_accept(w2, t);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("arb_second", w2, EXP_B2);
    wait_valid(w2, t, lat);
    chk("arb_second_result", (w2 == 1) ? resp1_result : resp0_result, (EXP_B2 == 1) ? 32'd7 : 32'd3);

    // Multiply dwell
    @(posedge clk); #1;
    set1(32'd6, 32'd7, 6'b000010);
    wait_accept(who, t);
    req1_valid = 1'b0;
    chk("mul_grant", who, 1);
    wait_valid(1, t, lat);
    chk("mul_latency", lat, MUL_LAT);
    chk("mul_result", resp1_result, 32'd42);

    // Held response blocks the other requester
    @(posedge clk); #1;
    resp0_ready = 1'b0;
    set0(32'd9, 32'd9, 6'b000001);
    wait_accept(who, t);
    req0_valid = 1'b0;
    set1(32'd2, 32'd3, 6'b000000);
    wait_valid(0, t, lat);
    chk("sub_latency", lat, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("sub_hold_valid", resp0_valid, 1'b1);
      chk("sub_hold_result", resp0_result, 32'd0);
      chk("sub_hold_zero", resp0_zero, 1'b1);
      chk("sub_block_req1", req1_ready, 1'b0);
    end
    @(posedge clk); #1;
    resp0_ready = 1'b1;
    wait_accept(who, t);
    req1_valid = 1'b0;
    chk("after_hold_grant", who, 1);
    wait_valid(1, t, lat);
    chk("after_hold_result", resp1_result, 32'd5);

    // Unsupported code
    @(posedge clk); #1;
    set0(32'd1, 32'd2, 6'b111111);
    wait_accept(who, t);
    req0_valid = 1'b0;
    wait_valid(0, t, lat);
    chk("unsup_result", resp0_result, 32'd0);
    chk("unsup_zero", resp0_zero, 1'b1);
    chk("unsup_ovf", resp0_overflow, 1'b0);

    // Reset during a multiply
    @(posedge clk); #1;
    set0(32'd1, 32'd1, 6'b000000);
    wait_accept(who, t);
    req0_valid = 1'b0;
    wait_valid(0, t, lat);
    chk("pre_rst_result", resp0_result, 32'd2);
    @(posedge clk); #1;
    set1(32'd3, 32'd4, 6'b000010);
    wait_accept(who, t);
    req1_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_resp1_valid", resp1_valid, 1'b0);
    chk("rst_exec_result", resp1_result, 32'd0);
    chk("rst_exec_zero", resp1_zero, 1'b0);
    chk("rst_exec_alu_a", alu_a, 32'd0);
    chk("rst_exec_alu_b", alu_b, 32'd0);
    chk("rst_exec_alu_fn", alu_fn, 6'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_exec_no_resp", resp1_valid, 1'b0);
    end

    // Pointer back at its reset preference
    @(posedge clk); #1;
    set0(32'd10, 32'd20, 6'b000101);
    set1(32'd30, 32'd40, 6'b000110);
    wait_accept(who, t);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("post_rst_grant", who, 0);
    wait_valid(0, t, lat);
    chk("post_rst_or", resp0_result, 32'd30);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
